// File: rtl/fe_pkg.sv
// Shared types and constants for the RV32I instruction-fetch front-end.
// Optional feature macro: FE_MISALIGN_TRAP_EN (adds the TRAP state).
package fe_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] FE_RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [XLEN-1:0] RV32I_NOP           = 32'h0000_0013;
    localparam logic [XLEN-1:0] FE_ALIGN_MASK       = 32'hFFFF_FFFC;

    typedef enum logic [6:0] {
        I_LOAD_TYPE   = 7'b0000011,
        I_ARITH_TYPE  = 7'b0010011,
        I_STORE_TYPE  = 7'b0100011,
        I_REG_TYPE    = 7'b0110011,
        I_BRANCH_TYPE = 7'b1100011,
        I_JALR_TYPE   = 7'b1100111,
        I_JAL_TYPE    = 7'b1101111,
        I_ENV_TYPE    = 7'b1110011
    } RV32I_OPCODE_t;

    typedef enum logic [2:0] {
        FE_IDLE,
        FE_REQ,
        FE_WAIT,
        FE_HOLD,
        FE_HALT
`ifdef FE_MISALIGN_TRAP_EN
        , FE_TRAP
`endif
    } FE_FETCH_STATE_t;

    typedef enum logic [1:0] {
        PC_SEL_HOLD,
        PC_SEL_INC,
        PC_SEL_REDIR,
        PC_SEL_PEND
    } FE_PC_SEL_t;

    // ECALL/EBREAK share the SYSTEM opcode; either one parks the front-end.
    function automatic logic fe_is_env(input logic [XLEN-1:0] instr);
        return instr[6:0] == I_ENV_TYPE;
    endfunction

endpackage

// File: rtl/fe_fetch_ctrl_if.sv
// Bus bundle between the fetch controller (master) and its environment:
// instruction memory, execute redirect and decode.
// Optional feature macro: FE_MISALIGN_TRAP_EN (adds exc_valid/exc_tval).
interface fe_fetch_ctrl_if;
    import fe_pkg::*;

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            de_valid;
    logic [XLEN-1:0] de_instr;
    logic [XLEN-1:0] de_pc;
    logic            de_ready;
`ifdef FE_MISALIGN_TRAP_EN
    logic            exc_valid;
    logic [XLEN-1:0] exc_tval;
`endif

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output de_valid, de_instr, de_pc,
        input  de_ready
`ifdef FE_MISALIGN_TRAP_EN
        , output exc_valid, exc_tval
`endif
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  de_valid, de_instr, de_pc,
        output de_ready
`ifdef FE_MISALIGN_TRAP_EN
        , input exc_valid, exc_tval
`endif
    );

endinterface

// File: rtl/fe_pc_gen.sv
// Next-pc selection (hold, pc+4, live redirect, pending redirect) and
// redirect-target alignment handling.
// Optional feature macro: FE_MISALIGN_TRAP_EN (keeps raw low bits and
// reports misalignment instead of clearing them).
module fe_pc_gen
    import fe_pkg::*;
(
    input  FE_PC_SEL_t      sel_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic [XLEN-1:0] pend_pc_i,
    output logic [XLEN-1:0] redir_tgt_o,
    output logic [XLEN-1:0] pc_next_o
`ifdef FE_MISALIGN_TRAP_EN
    ,
    output logic            redir_mis_o,
    output logic            pend_mis_o
`endif
);

`ifdef FE_MISALIGN_TRAP_EN
    // Raw target is kept so a trap can report the offending address.
    assign redir_tgt_o = redirect_pc_i;
    assign redir_mis_o = |redirect_pc_i[1:0];
    assign pend_mis_o  = |pend_pc_i[1:0];
`else
    // Without trapping, the low two bits of a target are simply dropped.
    assign redir_tgt_o = redirect_pc_i & FE_ALIGN_MASK;
`endif

    // Next-pc mux; the increment wraps modulo 2^32.
    always_comb begin
        pc_next_o = pc_i;
        unique case (sel_i)
            PC_SEL_INC:   pc_next_o = pc_i + XLEN'(4);
            PC_SEL_REDIR: pc_next_o = redir_tgt_o & FE_ALIGN_MASK;
            PC_SEL_PEND:  pc_next_o = pend_pc_i & FE_ALIGN_MASK;
            default:      pc_next_o = pc_i;
        endcase
    end

endmodule

// File: rtl/fe_fetch_ctrl.sv
// RV32I instruction-fetch controller: owns the pc, issues one outstanding
// imem request at a time, buffers one word for decode, squashes wrong-path
// responses after a redirect and parks after ECALL/EBREAK.
// Optional feature macro: FE_MISALIGN_TRAP_EN (misaligned redirect -> TRAP).
module fe_fetch_ctrl
    import fe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = FE_RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    fe_fetch_ctrl_if.master fe_bus
);

    FE_FETCH_STATE_t state_q, state_d;
    FE_PC_SEL_t      pc_sel;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] bpc_q, bpc_d;
    logic            req_valid_q, req_valid_d;
    logic            de_valid_q, de_valid_d;
    logic [XLEN-1:0] redir_tgt;
`ifdef FE_MISALIGN_TRAP_EN
    logic            redir_mis, pend_mis;
    logic            exc_valid_q, exc_valid_d;
    logic [XLEN-1:0] exc_tval_q, exc_tval_d;
`endif

    fe_pc_gen u_pc_gen (
        .sel_i         (pc_sel),
        .pc_i          (pc_q),
        .redirect_pc_i (fe_bus.redirect_pc),
        .pend_pc_i     (pend_pc_q),
        .redir_tgt_o   (redir_tgt),
        .pc_next_o     (pc_d)
`ifdef FE_MISALIGN_TRAP_EN
        ,
        .redir_mis_o   (redir_mis),
        .pend_mis_o    (pend_mis)
`endif
    );

    // State and datapath registers; reset also abandons any open request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FE_IDLE;
            pc_q        <= RESET_PC;
            pend_pc_q   <= RESET_PC;
            kill_q      <= 1'b0;
            instr_q     <= RV32I_NOP;
            bpc_q       <= RESET_PC;
            req_valid_q <= 1'b0;
            de_valid_q  <= 1'b0;
`ifdef FE_MISALIGN_TRAP_EN
            exc_valid_q <= 1'b0;
            exc_tval_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_pc_q   <= pend_pc_d;
            kill_q      <= kill_d;
            instr_q     <= instr_d;
            bpc_q       <= bpc_d;
            req_valid_q <= req_valid_d;
            de_valid_q  <= de_valid_d;
`ifdef FE_MISALIGN_TRAP_EN
            exc_valid_q <= exc_valid_d;
            exc_tval_q  <= exc_tval_d;
`endif
        end
    end

    // Next-state, pc select, kill flag and buffer capture.
    always_comb begin
        state_d   = state_q;
        pc_sel    = PC_SEL_HOLD;
        kill_d    = kill_q;
        pend_pc_d = pend_pc_q;
        instr_d   = instr_q;
        bpc_d     = bpc_q;
`ifdef FE_MISALIGN_TRAP_EN
        exc_tval_d = exc_tval_q;
`endif
        unique case (state_q)
            FE_IDLE: state_d = FE_REQ;
            FE_REQ: begin
                // The request stays up with its address; only remember the target.
                if (fe_bus.redirect_valid) begin
                    kill_d    = 1'b1;
                    pend_pc_d = redir_tgt;
                end
                if (fe_bus.imem_req_ready) state_d = FE_WAIT;
            end
            FE_WAIT: begin
                if (fe_bus.imem_rsp_valid) begin
                    if (kill_q || fe_bus.redirect_valid) begin
                        // Wrong-path word: drop it, the youngest target wins.
                        kill_d  = 1'b0;
                        pc_sel  = fe_bus.redirect_valid ? PC_SEL_REDIR : PC_SEL_PEND;
                        state_d = FE_REQ;
`ifdef FE_MISALIGN_TRAP_EN
                        if (fe_bus.redirect_valid ? redir_mis : pend_mis) begin
                            pc_sel     = PC_SEL_HOLD;
                            state_d    = FE_TRAP;
                            exc_tval_d = fe_bus.redirect_valid ? redir_tgt : pend_pc_q;
                        end
`endif
                    end else begin
                        instr_d = fe_bus.imem_rsp_data;
                        bpc_d   = pc_q;
                        state_d = FE_HOLD;
                    end
                end else if (fe_bus.redirect_valid) begin
                    kill_d    = 1'b1;
                    pend_pc_d = redir_tgt;
                end
            end
            FE_HOLD, FE_HALT: begin
                if (fe_bus.redirect_valid) begin
                    // Redirect beats a same-cycle decode handshake.
                    pc_sel  = PC_SEL_REDIR;
                    state_d = FE_REQ;
`ifdef FE_MISALIGN_TRAP_EN
                    if (redir_mis) begin
                        pc_sel     = PC_SEL_HOLD;
                        state_d    = FE_TRAP;
                        exc_tval_d = redir_tgt;
                    end
`endif
                end else if (state_q == FE_HOLD && fe_bus.de_ready) begin
                    if (fe_is_env(instr_q)) begin
                        state_d = FE_HALT;
                    end else begin
                        pc_sel  = PC_SEL_INC;
                        state_d = FE_REQ;
                    end
                end
            end
`ifdef FE_MISALIGN_TRAP_EN
            FE_TRAP: begin
                if (fe_bus.redirect_valid) begin
                    if (redir_mis) begin
                        exc_tval_d = redir_tgt;
                    end else begin
                        pc_sel  = PC_SEL_REDIR;
                        state_d = FE_REQ;
                    end
                end
            end
`endif
            default: state_d = FE_IDLE;
        endcase
    end

    // Registered outputs are decoded from the upcoming state.
    always_comb begin
        req_valid_d = (state_d == FE_REQ);
        de_valid_d  = (state_d == FE_HOLD);
`ifdef FE_MISALIGN_TRAP_EN
        exc_valid_d = (state_d == FE_TRAP);
`endif
    end

    assign fe_bus.imem_req_valid = req_valid_q;
    assign fe_bus.imem_req_addr  = pc_q;
    assign fe_bus.de_valid       = de_valid_q;
    assign fe_bus.de_instr       = instr_q;
    assign fe_bus.de_pc          = bpc_q;
`ifdef FE_MISALIGN_TRAP_EN
    assign fe_bus.exc_valid      = exc_valid_q;
    assign fe_bus.exc_tval       = exc_tval_q;
`endif

endmodule

// File: tb/tb_fe_fetch_ctrl.sv
// Directed bench for fe_fetch_ctrl; builds with or without FE_MISALIGN_TRAP_EN.
module tb_fe_fetch_ctrl;
    import fe_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passes = 0;

    fe_fetch_ctrl_if bus();

    fe_fetch_ctrl #(.RESET_PC(32'h0040_0000)) dut (
        .clk    (clk),
        .rst    (rst),
        .fe_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Starts in REQ with ready high; ends in HOLD with the word presented.
    task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] word);
        chk1({tag, "_req"}, bus.imem_req_valid, 1'b1);
        chk({tag, "_addr"}, bus.imem_req_addr, addr);
        tick();
        chk1({tag, "_dv_early"}, bus.de_valid, 1'b0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = word;
        tick();
        bus.imem_rsp_valid = 1'b0;
        chk1({tag, "_dv"}, bus.de_valid, 1'b1);
        chk({tag, "_instr"}, bus.de_instr, word);
        chk({tag, "_pc"}, bus.de_pc, addr);
    endtask

    initial begin
        rst                = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.de_ready       = 1'b0;
        repeat (2) tick();

        chk1("rst_req", bus.imem_req_valid, 1'b0);
        chk("rst_addr", bus.imem_req_addr, 32'h0040_0000);
        chk1("rst_dv", bus.de_valid, 1'b0);
        chk("rst_instr", bus.de_instr, 32'h0000_0013);
        chk("rst_pc", bus.de_pc, 32'h0040_0000);
`ifdef FE_MISALIGN_TRAP_EN
        chk1("rst_exc", bus.exc_valid, 1'b0);
        chk("rst_tval", bus.exc_tval, 32'h0);
`endif

        // First fetch after reset release
        rst = 1'b0;
        tick();
        do_fetch("first", 32'h0040_0000, 32'h0010_0093);
        bus.de_ready = 1'b1;
        tick();
        bus.de_ready = 1'b0;
        chk1("next_req", bus.imem_req_valid, 1'b1);
        chk("next_addr", bus.imem_req_addr, 32'h0040_0004);
        chk1("next_dv", bus.de_valid, 1'b0);

        // Request backpressure
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("bp_req", bus.imem_req_valid, 1'b1);
            chk("bp_addr", bus.imem_req_addr, 32'h0040_0004);
        end
        bus.imem_req_ready = 1'b1;
        do_fetch("bp", 32'h0040_0004, 32'h0020_0113);

        // Decode backpressure
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("dr_dv", bus.de_valid, 1'b1);
            chk("dr_instr", bus.de_instr, 32'h0020_0113);
            chk1("dr_noreq", bus.imem_req_valid, 1'b0);
        end
        bus.de_ready = 1'b1;
        tick();
        bus.de_ready = 1'b0;
        chk1("dr_req", bus.imem_req_valid, 1'b1);
        chk("dr_addr", bus.imem_req_addr, 32'h0040_0008);

        // Redirect while waiting for the response
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0040_0100;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        chk1("rw_noreq", bus.imem_req_valid, 1'b0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0030_0193;
        tick();
        bus.imem_rsp_valid = 1'b0;
        chk1("rw_dv", bus.de_valid, 1'b0);
        chk1("rw_req", bus.imem_req_valid, 1'b1);
        chk("rw_addr", bus.imem_req_addr, 32'h0040_0100);

        // Environment instruction parks the front-end
        do_fetch("env", 32'h0040_0100, 32'h0000_0073);
        bus.de_ready = 1'b1;
        tick();
        bus.de_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk1("halt_noreq", bus.imem_req_valid, 1'b0);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0040_0200;
        tick();
        bus.redirect_valid = 1'b0;
        chk1("halt_req", bus.imem_req_valid, 1'b1);
        chk("halt_addr", bus.imem_req_addr, 32'h0040_0200);

        // Redirect from HOLD drops the buffer; pc+4 wraps to zero
        do_fetch("pre_wrap", 32'h0040_0200, 32'h0040_0213);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        chk1("hold_drop_dv", bus.de_valid, 1'b0);
        do_fetch("wrap", 32'hFFFF_FFFC, 32'h0050_0293);
        bus.de_ready = 1'b1;
        tick();
        bus.de_ready = 1'b0;
        chk1("wrap_req", bus.imem_req_valid, 1'b1);
        chk("wrap_addr", bus.imem_req_addr, 32'h0000_0000);

        // Misaligned redirect issued while in REQ
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0040_0102;
        tick();
        bus.redirect_valid = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0060_0313;
        tick();
        bus.imem_rsp_valid = 1'b0;
        chk1("mis_dv", bus.de_valid, 1'b0);
`ifdef FE_MISALIGN_TRAP_EN
        chk1("mis_exc", bus.exc_valid, 1'b1);
        chk("mis_tval", bus.exc_tval, 32'h0040_0102);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("trap_noreq", bus.imem_req_valid, 1'b0);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0040_0300;
        tick();
        bus.redirect_valid = 1'b0;
        chk1("trap_exit_exc", bus.exc_valid, 1'b0);
        chk1("trap_exit_req", bus.imem_req_valid, 1'b1);
        chk("trap_exit_addr", bus.imem_req_addr, 32'h0040_0300);
`else
        chk1("mis_req", bus.imem_req_valid, 1'b1);
        chk("mis_addr", bus.imem_req_addr, 32'h0040_0100);
`endif

        // Two redirects while waiting: the younger target wins
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0040_0500;
        tick();
        bus.redirect_pc    = 32'h0040_0600;
        tick();
        bus.redirect_valid = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0070_0393;
        tick();
        bus.imem_rsp_valid = 1'b0;
        chk1("young_req", bus.imem_req_valid, 1'b1);
        chk("young_addr", bus.imem_req_addr, 32'h0040_0600);

        // Reset in the middle of a transaction
        tick();
        rst = 1'b1;
        #1;
        chk("mr_addr", bus.imem_req_addr, 32'h0040_0000);
        chk1("mr_req", bus.imem_req_valid, 1'b0);
        tick();
        rst = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0080_0413;
        tick();
        bus.imem_req_ready = 1'b0;
        chk1("mr_restart_req", bus.imem_req_valid, 1'b1);
        chk("mr_restart_addr", bus.imem_req_addr, 32'h0040_0000);
        tick();
        bus.imem_rsp_valid = 1'b0;
        chk1("mr_stray_dv", bus.de_valid, 1'b0);
        chk1("mr_stray_req", bus.imem_req_valid, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fe_fetch_ctrl.md
# fe_fetch_ctrl

Instruction-fetch controller for the RV32I front-end. Owns the program counter and sequences one-outstanding-request transactions on the instruction-memory port. Holds each fetched word in a one-entry buffer until decode accepts it. Squashes wrong-path fetches on redirects from execute, and parks the front-end after delivering an environment instruction (ECALL/EBREAK, opcode `I_ENV_TYPE`).

## Interface
- `RESET_PC`, 32'h0040_0000, first fetch address after reset
- `XLEN`, 32, address/instruction width
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `imem_req_valid` out 1: fetch request
- `imem_req_addr` out XLEN: fetch address, word aligned
- `imem_req_ready` in 1: memory accepts request
- `imem_rsp_valid` in 1: response data valid
- `imem_rsp_data` in XLEN: fetched instruction word
- `redirect_valid` in 1: branch/jump/trap-return target from execute
- `redirect_pc` in XLEN: redirect target
- `de_valid` out 1: instruction available to decode
- `de_instr` out XLEN: instruction word
- `de_pc` out XLEN: PC of `de_instr`
- `de_ready` in 1: decode accepts
- `exc_valid`, `exc_tval` out 1/XLEN: present only with `FE_MISALIGN_TRAP_EN`

## Operation
- **FSM states:** IDLE, REQ, WAIT, HOLD, HALT; TRAP is added with the macro.
- **IDLE → REQ:** unconditional on the first clock after reset release.
- **REQ:**
  - `imem_req_valid`=1 and `imem_req_addr`=pc.
  - Valid and address stay stable until `imem_req_ready`.
  - valid&ready → WAIT.
- **WAIT:**
  - On `imem_rsp_valid`, capture data and the current pc into the buffer → HOLD.
  - If the kill flag is set, discard the response, clear the flag, load pc←redirect target → REQ.
- **HOLD:**
  - `de_valid`=1.
  - On `de_ready`: if `de_instr[6:0]`==`I_ENV_TYPE` → HALT; otherwise pc←pc+4 → REQ.
- **HALT:** no requests; leave only on `redirect_valid` (pc←target → REQ).
- **Redirect handling:**
  - In REQ or WAIT: latch the target in `pend_pc` and set the kill flag. Any in-flight or still-unaccepted request completes normally; its response is dropped.
  - In HOLD: drop the buffer (`de_valid`→0 next cycle), pc←target → REQ.
  - Redirect in the same cycle as a de handshake: FE treats the word as consumed; decode squashes it itself. Redirect wins the next-state choice.
  - A second redirect while kill is pending overwrites `pend_pc` (youngest wins).
- **Arithmetic:** pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- **Protocol violations:** `imem_rsp_valid` outside WAIT is ignored.
- **Misaligned redirect without macro:** `redirect_pc[1:0]` is forced to 0.

## Timing
- **Reset values:** `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`, `de_valid`=0, `de_instr`=32'h0000_0013 (NOP), `de_pc`=`RESET_PC`, kill=0, state=IDLE. `exc_valid`=0 and `exc_tval`=0 (macro only).
- **Reset mid-transaction:** abandons the request immediately; no response is tracked afterwards.
- **Outputs:** all registered; no combinational path from any input to any output.
- **Latency:** request accepted at cycle t and response at t+k gives `de_valid` at t+k+1.
- **Next request:** asserted the cycle after the de handshake.
- **Zero-wait throughput:** 1 instruction per 3 cycles.
- **Redirect to next request:**
  - From HOLD/HALT: request asserted 1 cycle after the redirect.
  - From WAIT: request asserted 1 cycle after the killed response arrives.

## Configuration
- **`FE_MISALIGN_TRAP_EN` defined:**
  - A redirect with `redirect_pc[1:0]`≠0 enters TRAP (after any in-flight response is drained).
  - In TRAP: `exc_valid`=1, `exc_tval`=offending target, no fetches.
  - TRAP is left only by an aligned redirect → REQ.
  - A misaligned redirect while in TRAP updates `exc_tval`.
- **Undefined:** `exc_*` ports absent; target low bits are cleared.

## Structure
- **Shared in `fe_pkg`:**
  - `FE_FETCH_STATE_t` enum.
  - `RV32I_NOP` constant (32'h0000_0013).
  - `FE_RESET_PC_DEFAULT`.
  - Reuse `RV32I_OPCODE_t`/`I_ENV_TYPE` for the predecode.
- **Sub-module:** one, `fe_pc_gen` — next-pc mux (pc+4, redirect, pend_pc) plus alignment handling. FSM, kill flag and buffer stay in the top.

## Test plan
- **Reset and first fetch:** deassert rst, memory always ready, 1-cycle response of 32'h0010_0093 → first req addr 32'h0040_0000; `de_valid` at cycle 4 with `de_pc`=32'h0040_0000; next req addr 32'h0040_0004.
- **Backpressure:** `imem_req_ready` low for 5 cycles → addr/valid stable throughout. `de_ready` low for 4 cycles → `de_instr` held, no new request issued.
- **Redirect while in WAIT:** redirect_pc=32'h0040_0100 → the late response is not presented; next req addr 32'h0040_0100.
- **Environment halt:** fetch 32'h0000_0073 (ECALL), de handshake → no requests for 20 cycles. Redirect to 32'h0040_0200 → request issued the next cycle.
- **Wrap-around:** redirect to 32'hFFFF_FFFC and fetch a non-env word → following req addr 32'h0000_0000.
- **Misaligned redirect:** redirect to 32'h0040_0102.
  - With macro: `exc_valid`=1, `exc_tval`=32'h0040_0102, no requests; an aligned redirect resumes fetching.
  - Without macro: req addr 32'h0040_0100.
